// File: rtl/id_stage_if.sv
// D-side inputs, writeback port and D->E register outputs of the decode stage.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic [31:0]     instrD;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] PCplus4D;
    logic            RegWriteW;
    logic [4:0]      RdW;
    logic [XLEN-1:0] ResultW;
    logic            FlushE;

    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] PCplus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            RegWriteE;
    logic            MemWriteE;
    logic            BranchE;
    logic            JumpE;
    logic            ALUSrcE;
    logic [1:0]      ResultSrcE;
    logic [2:0]      ALUControlE;
    logic            IllegalE;

    modport master (
        output instrD, PCD, PCplus4D, RegWriteW, RdW, ResultW, FlushE,
        input  RD1E, RD2E, ImmExtE, PCE, PCplus4E, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
               ResultSrcE, ALUControlE, IllegalE
    );

    modport slave (
        input  instrD, PCD, PCplus4D, RegWriteW, RdW, ResultW, FlushE,
        output RD1E, RD2E, ImmExtE, PCE, PCplus4E, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE,
               ResultSrcE, ALUControlE, IllegalE
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode stage: register file, control/ALU decode, immediates, D->E register.
// Optional macro ID_RF_BYPASS_EN: register file read sees a same-cycle writeback.
module id_stage #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_sel_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign instr    = bus.instrD;
    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    // ---------------- register file ----------------
    logic [XLEN-1:0] rf_reg [NREG];
    logic [NREG-1:0] rf_we;

    assign rf_we[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_rf_we
            assign rf_we[gi] = bus.RegWriteW && (bus.RdW == 5'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (rf_we[i]) begin
                    rf_reg[i] <= bus.ResultW;
                end
            end
        end
    end

    logic [XLEN-1:0] rd1_next;
    logic [XLEN-1:0] rd2_next;

`ifdef ID_RF_BYPASS_EN
    // Write-through: a read of the register being written returns the new data.
    assign rd1_next = (rs1 == 5'd0) ? '0 :
                      (bus.RegWriteW && bus.RdW == rs1) ? bus.ResultW : rf_reg[rs1];
    assign rd2_next = (rs2 == 5'd0) ? '0 :
                      (bus.RegWriteW && bus.RdW == rs2) ? bus.ResultW : rf_reg[rs2];
`else
    assign rd1_next = (rs1 == 5'd0) ? '0 : rf_reg[rs1];
    assign rd2_next = (rs2 == 5'd0) ? '0 : rf_reg[rs2];
`endif

    // ---------------- main decode ----------------
    logic       regwrite_next;
    logic       memwrite_next;
    logic       branch_next;
    logic       jump_next;
    logic       alusrc_next;
    logic [1:0] resultsrc_next;
    logic [1:0] alu_op;
    imm_sel_t   imm_sel;
    logic       opcode_illegal;

    always_comb begin
        regwrite_next  = 1'b0;
        memwrite_next  = 1'b0;
        branch_next    = 1'b0;
        jump_next      = 1'b0;
        alusrc_next    = 1'b0;
        resultsrc_next = 2'b00;
        alu_op         = ALUOP_ADD;
        imm_sel        = IMM_NONE;
        opcode_illegal = 1'b0;
        case (opcode)
            OP_LOAD: begin
                regwrite_next  = 1'b1;
                alusrc_next    = 1'b1;
                resultsrc_next = 2'b01;
                imm_sel        = IMM_I;
            end
            OP_STORE: begin
                memwrite_next = 1'b1;
                alusrc_next   = 1'b1;
                imm_sel       = IMM_S;
            end
            OP_RTYPE: begin
                regwrite_next = 1'b1;
                alu_op        = ALUOP_FUNCT;
            end
            OP_IALU: begin
                regwrite_next = 1'b1;
                alusrc_next   = 1'b1;
                alu_op        = ALUOP_FUNCT;
                imm_sel       = IMM_I;
            end
            OP_BRANCH: begin
                branch_next = 1'b1;
                alu_op      = ALUOP_SUB;
                imm_sel     = IMM_B;
            end
            OP_JAL: begin
                regwrite_next  = 1'b1;
                jump_next      = 1'b1;
                resultsrc_next = 2'b10;
                imm_sel        = IMM_J;
            end
            default: begin
                opcode_illegal = 1'b1;
            end
        endcase
    end

    // ---------------- ALU decode ----------------
    logic [2:0] alucontrol_next;
    logic       funct_illegal;
    logic       illegal_next;

    always_comb begin
        alucontrol_next = ALU_ADD;
        funct_illegal   = 1'b0;
        case (alu_op)
            ALUOP_SUB: alucontrol_next = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only register-register add can become sub; addi ignores bit 30.
                    3'b000:  alucontrol_next = (opcode == OP_RTYPE && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol_next = ALU_SLT;
                    3'b110:  alucontrol_next = ALU_OR;
                    3'b111:  alucontrol_next = ALU_AND;
                    default: funct_illegal   = 1'b1;
                endcase
            end
            default: alucontrol_next = ALU_ADD;
        endcase
    end

    assign illegal_next = opcode_illegal | funct_illegal;

    // ---------------- immediate generation ----------------
    logic [XLEN-1:0] immext_next;

    always_comb begin
        immext_next = '0;
        case (imm_sel)
            IMM_I: immext_next = {{(XLEN-12){instr[31]}}, instr[31:20]};
            IMM_S: immext_next = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: immext_next = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            IMM_J: immext_next = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            default: immext_next = '0;
        endcase
    end

    // ---------------- D->E pipeline register ----------------
    logic [XLEN-1:0] rd1e_reg;
    logic [XLEN-1:0] rd2e_reg;
    logic [XLEN-1:0] immexte_reg;
    logic [XLEN-1:0] pce_reg;
    logic [XLEN-1:0] pcplus4e_reg;
    logic [4:0]      rs1e_reg;
    logic [4:0]      rs2e_reg;
    logic [4:0]      rde_reg;
    logic            regwritee_reg;
    logic            memwritee_reg;
    logic            branche_reg;
    logic            jumpe_reg;
    logic            alusrce_reg;
    logic [1:0]      resultsrce_reg;
    logic [2:0]      alucontrole_reg;
    logic            illegale_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.FlushE) begin
            // Reset and flush both leave a full bubble, including IllegalE.
            rd1e_reg        <= '0;
            rd2e_reg        <= '0;
            immexte_reg     <= '0;
            pce_reg         <= '0;
            pcplus4e_reg    <= '0;
            rs1e_reg        <= '0;
            rs2e_reg        <= '0;
            rde_reg         <= '0;
            regwritee_reg   <= 1'b0;
            memwritee_reg   <= 1'b0;
            branche_reg     <= 1'b0;
            jumpe_reg       <= 1'b0;
            alusrce_reg     <= 1'b0;
            resultsrce_reg  <= 2'b00;
            alucontrole_reg <= 3'b000;
            illegale_reg    <= 1'b0;
        end else begin
            rd1e_reg        <= rd1_next;
            rd2e_reg        <= rd2_next;
            immexte_reg     <= immext_next;
            pce_reg         <= bus.PCD;
            pcplus4e_reg    <= bus.PCplus4D;
            rs1e_reg        <= rs1;
            rs2e_reg        <= rs2;
            rde_reg         <= rd;
            regwritee_reg   <= regwrite_next;
            memwritee_reg   <= memwrite_next;
            branche_reg     <= branch_next;
            jumpe_reg       <= jump_next;
            alusrce_reg     <= alusrc_next;
            resultsrce_reg  <= resultsrc_next;
            alucontrole_reg <= alucontrol_next;
            illegale_reg    <= illegal_next;
        end
    end

    assign bus.RD1E        = rd1e_reg;
    assign bus.RD2E        = rd2e_reg;
    assign bus.ImmExtE     = immexte_reg;
    assign bus.PCE         = pce_reg;
    assign bus.PCplus4E    = pcplus4e_reg;
    assign bus.Rs1E        = rs1e_reg;
    assign bus.Rs2E        = rs2e_reg;
    assign bus.RdE         = rde_reg;
    assign bus.RegWriteE   = regwritee_reg;
    assign bus.MemWriteE   = memwritee_reg;
    assign bus.BranchE     = branche_reg;
    assign bus.JumpE       = jumpe_reg;
    assign bus.ALUSrcE     = alusrce_reg;
    assign bus.ResultSrcE  = resultsrce_reg;
    assign bus.ALUControlE = alucontrole_reg;
    assign bus.IllegalE    = illegale_reg;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed cases plus randomized traffic against a behavioural model.
module tb_id_stage;

    logic clk;
    logic rst;
    logic check_en;
    int unsigned n_checks;
    int unsigned n_fail;

    id_stage_if #(.XLEN(32)) bus ();

    id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rw;
        logic        mw;
        logic        br;
        logic        jp;
        logic        asrc;
        logic [1:0]  rsrc;
        logic [2:0]  actl;
        logic        ill;
        logic        imm_care;
        logic        asrc_care;
        logic        actl_care;
    } exp_t;

    logic [31:0] mrf [32];
    exp_t        exp_q;
    int unsigned txn;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural register read as seen during the current D cycle.
    function automatic logic [31:0] model_read(input logic [4:0] r);
        if (r == 5'd0) return 32'h0;
`ifdef ID_RF_BYPASS_EN
        if (bus.RegWriteW && bus.RdW == r) return bus.ResultW;
`endif
        return mrf[r];
    endfunction

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                          input logic [31:0] pc4);
        exp_t e;
        logic signed [31:0] imm_i, imm_s, imm_b, imm_j;
        e = '0;
        e.rd1 = model_read(ins[19:15]);
        e.rd2 = model_read(ins[24:20]);
        e.pc  = pc;
        e.pc4 = pc4;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.imm_care  = 1'b1;
        e.asrc_care = 1'b1;
        e.actl_care = 1'b1;
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_j = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        case (ins[6:0])
            7'b0000011: begin e.rw = 1; e.asrc = 1; e.rsrc = 2'b01; e.imm = imm_i; end
            7'b0100011: begin e.mw = 1; e.asrc = 1; e.imm = imm_s; end
            7'b1100011: begin e.br = 1; e.actl = 3'b001; e.imm = imm_b; end
            7'b1101111: begin
                e.rw = 1; e.jp = 1; e.rsrc = 2'b10; e.imm = imm_j;
                e.asrc_care = 0; e.actl_care = 0;
            end
            7'b0110011, 7'b0010011: begin
                e.rw = 1;
                if (ins[6:0] == 7'b0010011) begin
                    e.asrc = 1;
                    e.imm  = imm_i;
                end else begin
                    e.imm_care = 0;
                end
                case (ins[14:12])
                    3'b000:  e.actl = (ins[5] && ins[30]) ? 3'b001 : 3'b000;
                    3'b010:  e.actl = 3'b101;
                    3'b110:  e.actl = 3'b011;
                    3'b111:  e.actl = 3'b010;
                    default: begin e.actl = 3'b000; e.ill = 1; end
                endcase
            end
            default: begin e.ill = 1; e.imm_care = 0; end
        endcase
        return e;
    endfunction

    // Reference model: expected E outputs after each edge, plus the architectural register file.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= '0;
            for (int i = 0; i < 32; i++) mrf[i] <= 32'h0;
        end else begin
            if (bus.FlushE) begin
                exp_q           <= '0;
                exp_q.imm_care  <= 1'b1;
                exp_q.asrc_care <= 1'b1;
                exp_q.actl_care <= 1'b1;
            end else begin
                exp_q <= model_decode(bus.instrD, bus.PCD, bus.PCplus4D);
            end
            if (bus.RegWriteW && bus.RdW != 5'd0) mrf[bus.RdW] <= bus.ResultW;
        end
    end

    // Compare process: every cycle the outputs are meaningful.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            txn++;
            $display("txn %0d: pc=%h rd=%0d rd1=%h rd2=%h imm=%h rw=%0d mw=%0d br=%0d jp=%0d alu=%0d ill=%0d",
                     txn, bus.PCE, bus.RdE, bus.RD1E, bus.RD2E, bus.ImmExtE, bus.RegWriteE,
                     bus.MemWriteE, bus.BranchE, bus.JumpE, bus.ALUControlE, bus.IllegalE);
            chk("RD1E", bus.RD1E, exp_q.rd1);
            chk("RD2E", bus.RD2E, exp_q.rd2);
            if (exp_q.imm_care) chk("ImmExtE", bus.ImmExtE, exp_q.imm);
            chk("PCE", bus.PCE, exp_q.pc);
            chk("PCplus4E", bus.PCplus4E, exp_q.pc4);
            chk("Rs1E", 32'(bus.Rs1E), 32'(exp_q.rs1));
            chk("Rs2E", 32'(bus.Rs2E), 32'(exp_q.rs2));
            chk("RdE", 32'(bus.RdE), 32'(exp_q.rd));
            chk("RegWriteE", 32'(bus.RegWriteE), 32'(exp_q.rw));
            chk("MemWriteE", 32'(bus.MemWriteE), 32'(exp_q.mw));
            chk("BranchE", 32'(bus.BranchE), 32'(exp_q.br));
            chk("JumpE", 32'(bus.JumpE), 32'(exp_q.jp));
            if (exp_q.asrc_care) chk("ALUSrcE", 32'(bus.ALUSrcE), 32'(exp_q.asrc));
            chk("ResultSrcE", 32'(bus.ResultSrcE), 32'(exp_q.rsrc));
            if (exp_q.actl_care) chk("ALUControlE", 32'(bus.ALUControlE), 32'(exp_q.actl));
            chk("IllegalE", 32'(bus.IllegalE), 32'(exp_q.ill));
        end
    end

    task automatic cycle(input logic [31:0] ins, input logic [31:0] pc, input logic rw,
                         input logic [4:0] rdw, input logic [31:0] res, input logic fl);
        @(negedge clk);
        bus.instrD    = ins;
        bus.PCD       = pc;
        bus.PCplus4D  = pc + 32'd4;
        bus.RegWriteW = rw;
        bus.RdW       = rdw;
        bus.ResultW   = res;
        bus.FlushE    = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " RD1E"}, bus.RD1E, 32'h0);
        chk({tag, " ImmExtE"}, bus.ImmExtE, 32'h0);
        chk({tag, " PCE"}, bus.PCE, 32'h0);
        chk({tag, " RdE"}, 32'(bus.RdE), 32'h0);
        chk({tag, " RegWriteE"}, 32'(bus.RegWriteE), 32'h0);
        chk({tag, " ALUSrcE"}, 32'(bus.ALUSrcE), 32'h0);
        chk({tag, " IllegalE"}, 32'(bus.IllegalE), 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  ops [6];
        int k;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;
        ins = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6) ins[6:0] = ops[k];
        else if (k == 8) ins = 32'h0;
        if ($urandom_range(0, 1) == 1) begin
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
        end
        return ins;
    endfunction

    logic [31:0] ins_r;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        txn      = 0;
        check_en = 1'b0;
        rst      = 1'b0;
        bus.instrD = '0; bus.PCD = '0; bus.PCplus4D = '0;
        bus.RegWriteW = 1'b0; bus.RdW = '0; bus.ResultW = '0; bus.FlushE = 1'b0;
        #1 rst = 1'b1;
        #2 chk_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        cycle(32'h00500093, 32'h10, 0, 0, 0, 0);   // addi x1,x0,5
        check_en = 1'b1;
        chk("addi ImmExtE", bus.ImmExtE, 32'd5);
        chk("addi RdE", 32'(bus.RdE), 32'd1);
        chk("addi RD1E", bus.RD1E, 32'd0);
        chk("addi PCE", bus.PCE, 32'h10);
        chk("addi RegWriteE", 32'(bus.RegWriteE), 32'd1);
        chk("addi ALUSrcE", 32'(bus.ALUSrcE), 32'd1);
        chk("addi ALUControlE", 32'(bus.ALUControlE), 32'd0);

        cycle(32'h0, 32'h14, 1, 5'd5, 32'hDEADBEEF, 0);
        cycle(32'h00028333, 32'h18, 0, 0, 0, 0);   // add x6,x5,x0
        chk("add RD1E", bus.RD1E, 32'hDEADBEEF);
        chk("add RD2E", bus.RD2E, 32'h0);
        chk("add ALUControlE", 32'(bus.ALUControlE), 32'd0);

        cycle(32'h0, 32'h1C, 1, 5'd0, 32'hCAFEF00D, 0);
        cycle(32'h00000333, 32'h20, 0, 0, 0, 0);
        chk("x0 RD1E", bus.RD1E, 32'h0);
        chk("x0 RD2E", bus.RD2E, 32'h0);

        cycle(32'hFE208EE3, 32'h24, 0, 0, 0, 0);   // beq x1,x2,-4
        chk("beq ImmExtE", bus.ImmExtE, 32'hFFFFFFFC);
        chk("beq BranchE", 32'(bus.BranchE), 32'd1);
        chk("beq ALUControlE", 32'(bus.ALUControlE), 32'd1);
        chk("beq RegWriteE", 32'(bus.RegWriteE), 32'd0);

        cycle(32'h0020A423, 32'h28, 0, 0, 0, 0);   // sw x2,8(x1)
        chk("sw ImmExtE", bus.ImmExtE, 32'd8);
        chk("sw MemWriteE", 32'(bus.MemWriteE), 32'd1);

        cycle(32'h008000EF, 32'h2C, 0, 0, 0, 0);   // jal x1,8
        chk("jal ImmExtE", bus.ImmExtE, 32'd8);
        chk("jal JumpE", 32'(bus.JumpE), 32'd1);
        chk("jal ResultSrcE", 32'(bus.ResultSrcE), 32'd2);

        cycle(32'h00500093, 32'h30, 0, 0, 0, 1);   // flushed addi
        chk_all_zero("flush");

        cycle(32'hFFFFFFFF, 32'h34, 0, 0, 0, 0);
        chk("ffff IllegalE", 32'(bus.IllegalE), 32'd1);
        chk("ffff RegWriteE", 32'(bus.RegWriteE), 32'd0);
        chk("ffff MemWriteE", 32'(bus.MemWriteE), 32'd0);
        chk("ffff BranchE", 32'(bus.BranchE), 32'd0);
        chk("ffff JumpE", 32'(bus.JumpE), 32'd0);
        chk("ffff ResultSrcE", 32'(bus.ResultSrcE), 32'd0);

        cycle(32'h0, 32'h38, 1, 5'd7, 32'h5555, 0);
        cycle(32'h00038433, 32'h3C, 1, 5'd7, 32'h1234, 0);   // add x8,x7,x0 during write
`ifdef ID_RF_BYPASS_EN
        chk("same-cycle RD1E", bus.RD1E, 32'h1234);
`else
        chk("same-cycle RD1E", bus.RD1E, 32'h5555);
`endif
        cycle(32'h00038433, 32'h40, 0, 0, 0, 0);
        chk("after-write RD1E", bus.RD1E, 32'h1234);

        for (int n = 0; n < 1500; n++) begin
            cycle(rand_instr(), $urandom & 32'hFFFFFFFC, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset in the middle of a cycle with live E outputs.
        cycle(32'h00500093, 32'h44, 0, 0, 0, 0);
        check_en = 1'b0;
        #1 rst = 1'b1;
        #1 chk_all_zero("mid reset");
        @(negedge clk);
        rst = 1'b0;
        bus.RegWriteW = 1'b0;
        bus.FlushE    = 1'b0;
        for (int r = 1; r < 32; r++) begin
            ins_r = 32'h33;
            ins_r[19:15] = 5'(r);
            ins_r[24:20] = 5'(r);
            cycle(ins_r, 32'h100 + 32'(r * 4), 0, 0, 0, 0);
            check_en = 1'b1;
            chk("post-reset RD1E", bus.RD1E, 32'h0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
